conductance_lif_neuron_unit: RTL and testbench

Time-multiplexed conductance-based leaky integrate-and-fire neuron datapath. Each update takes one neuron's state (Vmem, gex, gin, RefVal) plus its excitatory and inhibitory weight sums. It integrates one Euler step of DeltaT and returns the registered next state and a spike flag. External neuron RAM or a host writes the state back. Per-type constants (EX/IN) are selected by NeuronType.

---
 rtl/conductance_lif_neuron_unit.sv | 192 +++++++++++++++++++
 tb/tb_conductance_lif_neuron_unit.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/conductance_lif_neuron_unit.sv
// Conductance-based LIF neuron datapath: one Euler step of Vmem/gex/gin per update, registered outputs.
// Define ADAPTIVE_THRESHOLD_EN to compare against the per-neuron Threshold port instead of Threshold_EX/_IN.
module conductance_lif_neuron_unit #(
  parameter int unsigned INTEGER_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH_FRAC = 32,
  parameter int unsigned DATA_WIDTH      = INTEGER_WIDTH + DATA_WIDTH_FRAC,
  parameter int unsigned DELTAT_WIDTH    = 4,
  parameter int unsigned TREF_WIDTH      = 5,
  parameter int unsigned EXTEND_WIDTH    = (TREF_WIDTH + 3) * 2
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     UpdateEnable,
  input  logic                     Initialize,
  input  logic                     NeuronType,
  input  logic [INTEGER_WIDTH-1:0] RestVoltage_EX,
  input  logic [INTEGER_WIDTH-1:0] RestVoltage_IN,
  input  logic [INTEGER_WIDTH-1:0] Taumembrane_EX,
  input  logic [INTEGER_WIDTH-1:0] Taumembrane_IN,
  input  logic [INTEGER_WIDTH-1:0] ExReversal_EX,
  input  logic [INTEGER_WIDTH-1:0] ExReversal_IN,
  input  logic [INTEGER_WIDTH-1:0] InReversal_EX,
  input  logic [INTEGER_WIDTH-1:0] InReversal_IN,
  input  logic [INTEGER_WIDTH-1:0] TauExCon_EX,
  input  logic [INTEGER_WIDTH-1:0] TauExCon_IN,
  input  logic [INTEGER_WIDTH-1:0] TauInCon_EX,
  input  logic [INTEGER_WIDTH-1:0] TauInCon_IN,
  input  logic [INTEGER_WIDTH-1:0] ResetVoltage_EX,
  input  logic [INTEGER_WIDTH-1:0] ResetVoltage_IN,
  input  logic [TREF_WIDTH-1:0]    Refractory_EX,
  input  logic [TREF_WIDTH-1:0]    Refractory_IN,
  input  logic [DATA_WIDTH-1:0]    Threshold_EX,
  input  logic [DATA_WIDTH-1:0]    Threshold_IN,
  input  logic [DATA_WIDTH-1:0]    Threshold,
  input  logic [DATA_WIDTH-1:0]    Vmem,
  input  logic [DATA_WIDTH-1:0]    gex,
  input  logic [DATA_WIDTH-1:0]    gin,
  input  logic [TREF_WIDTH+2:0]    RefVal,
  input  logic [DELTAT_WIDTH-1:0]  DeltaT,
  input  logic [DATA_WIDTH-1:0]    ExWeightSum,
  input  logic [DATA_WIDTH-1:0]    InWeightSum,
  output logic                     SpikeBuffer,
  output logic [DATA_WIDTH-1:0]    VmemOut,
  output logic [DATA_WIDTH-1:0]    gexOut,
  output logic [DATA_WIDTH-1:0]    ginOut,
  output logic [TREF_WIDTH+2:0]    RefValOut
);

  localparam int unsigned REF_W  = TREF_WIDTH + 3;
  // Wide enough for Q32.32 x (Q33.32 difference) products plus the DeltaT scaling.
  localparam int unsigned WIDE_W = 2 * DATA_WIDTH + 8;

  typedef logic signed [WIDE_W-1:0] wide_t;

  function automatic wide_t sx(input logic [DATA_WIDTH-1:0] v);
    return wide_t'($signed(v));
  endfunction

  function automatic wide_t int_to_fix(input logic [INTEGER_WIDTH-1:0] v);
    return wide_t'($signed(v)) <<< DATA_WIDTH_FRAC;
  endfunction

  function automatic wide_t mul_q(input wide_t a, input wide_t b);
    return (a * b) >>> DATA_WIDTH_FRAC;
  endfunction

  function automatic wide_t scale_dt(input wide_t x, input logic [DELTAT_WIDTH-1:0] dt);
    wide_t dtw;
    dtw = wide_t'(dt);
    return (x * dtw) >>> DELTAT_WIDTH;
  endfunction

  // Zero tau disables the decay term, leaving the quantity unchanged.
  function automatic wide_t div_tau(input wide_t x, input logic [INTEGER_WIDTH-1:0] tau);
    wide_t t;
    t = wide_t'($signed(tau));
    if (tau == '0) return '0;
    return x / t;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] sat(input wide_t x);
    wide_t hi;
    wide_t lo;
    hi = wide_t'({1'b0, {(DATA_WIDTH-1){1'b1}}});
    lo = ~hi;
    if (x > hi) return {1'b0, {(DATA_WIDTH-1){1'b1}}};
    if (x < lo) return {1'b1, {(DATA_WIDTH-1){1'b0}}};
    return x[DATA_WIDTH-1:0];
  endfunction

  logic                     spike_q, spike_d;
  logic [DATA_WIDTH-1:0]    vmem_q, vmem_d;
  logic [DATA_WIDTH-1:0]    gex_q, gex_d;
  logic [DATA_WIDTH-1:0]    gin_q, gin_d;
  logic [REF_W-1:0]         refval_q, refval_d;

  logic [INTEGER_WIDTH-1:0] sel_rest, sel_taum, sel_exrev, sel_inrev;
  logic [INTEGER_WIDTH-1:0] sel_tauex, sel_tauin, sel_reset;
  logic [TREF_WIDTH-1:0]    sel_tref;
  logic [DATA_WIDTH-1:0]    sel_thr;

  assign sel_rest  = NeuronType ? RestVoltage_IN  : RestVoltage_EX;
  assign sel_taum  = NeuronType ? Taumembrane_IN  : Taumembrane_EX;
  assign sel_exrev = NeuronType ? ExReversal_IN   : ExReversal_EX;
  assign sel_inrev = NeuronType ? InReversal_IN   : InReversal_EX;
  assign sel_tauex = NeuronType ? TauExCon_IN     : TauExCon_EX;
  assign sel_tauin = NeuronType ? TauInCon_IN     : TauInCon_EX;
  assign sel_reset = NeuronType ? ResetVoltage_IN : ResetVoltage_EX;
  assign sel_tref  = NeuronType ? Refractory_IN   : Refractory_EX;

`ifdef ADAPTIVE_THRESHOLD_EN
  logic unused_static_thr;
  assign sel_thr           = Threshold;
  assign unused_static_thr = ^{Threshold_EX, Threshold_IN};
`else
  logic unused_adaptive_thr;
  assign sel_thr             = NeuronType ? Threshold_IN : Threshold_EX;
  assign unused_adaptive_thr = ^Threshold;
`endif

  wide_t vmem_w, drive_w, vnew_w, gex_new_w, gin_new_w;

  // Membrane drive: leak toward rest plus both conductance currents, all from pre-update state.
  assign vmem_w    = sx(Vmem);
  assign drive_w   = (int_to_fix(sel_rest) - vmem_w)
                   + mul_q(sx(gex), int_to_fix(sel_exrev) - vmem_w)
                   + mul_q(sx(gin), int_to_fix(sel_inrev) - vmem_w);
  assign vnew_w    = vmem_w + div_tau(scale_dt(drive_w, DeltaT), sel_taum);
  assign gex_new_w = sx(gex) - div_tau(scale_dt(sx(gex), DeltaT), sel_tauex) + sx(ExWeightSum);
  assign gin_new_w = sx(gin) - div_tau(scale_dt(sx(gin), DeltaT), sel_tauin) + sx(InWeightSum);

  logic [EXTEND_WIDTH-1:0] ref_ext, dt_ext, ref_dec, ref_load;

  assign ref_ext  = EXTEND_WIDTH'(RefVal);
  assign dt_ext   = EXTEND_WIDTH'(DeltaT);
  assign ref_dec  = (ref_ext > dt_ext) ? (ref_ext - dt_ext) : '0;
  assign ref_load = EXTEND_WIDTH'(sel_tref) << 4;

  always_comb begin
    spike_d  = spike_q;
    vmem_d   = vmem_q;
    gex_d    = gex_q;
    gin_d    = gin_q;
    refval_d = refval_q;
    if (Initialize) begin
      spike_d  = 1'b0;
      vmem_d   = sat(int_to_fix(sel_reset));
      gex_d    = '0;
      gin_d    = '0;
      refval_d = '0;
    end else if (UpdateEnable) begin
      gex_d = sat(gex_new_w);
      gin_d = sat(gin_new_w);
      if (RefVal != '0) begin
        spike_d  = 1'b0;
        vmem_d   = Vmem;
        refval_d = REF_W'(ref_dec);
      end else if (vnew_w >= sx(sel_thr)) begin
        spike_d  = 1'b1;
        vmem_d   = sat(int_to_fix(sel_reset));
        refval_d = REF_W'(ref_load);
      end else begin
        spike_d  = 1'b0;
        vmem_d   = sat(vnew_w);
        refval_d = '0;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      spike_q  <= 1'b0;
      vmem_q   <= '0;
      gex_q    <= '0;
      gin_q    <= '0;
      refval_q <= '0;
    end else begin
      spike_q  <= spike_d;
      vmem_q   <= vmem_d;
      gex_q    <= gex_d;
      gin_q    <= gin_d;
      refval_q <= refval_d;
    end
  end

  assign SpikeBuffer = spike_q;
  assign VmemOut     = vmem_q;
  assign gexOut      = gex_q;
  assign ginOut      = gin_q;
  assign RefValOut   = refval_q;

endmodule

// File: tb/tb_conductance_lif_neuron_unit.sv
// Scoreboard bench for conductance_lif_neuron_unit: driver queues hand-computed results, monitor checks them.
module tb_conductance_lif_neuron_unit;

  localparam logic [63:0] ONE  = 64'h0000_0001_0000_0000;
  localparam logic [63:0] HALF = 64'h0000_0000_8000_0000;
  localparam logic [63:0] MAXV = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;

  typedef struct packed {
    logic        spike;
    logic [63:0] vmem;
    logic [63:0] gex;
    logic [63:0] gin;
    logic [7:0]  refval;
  } exp_t;

  logic Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic        Reset, UpdateEnable, Initialize, NeuronType;
  logic [31:0] RestVoltage_EX, RestVoltage_IN, Taumembrane_EX, Taumembrane_IN;
  logic [31:0] ExReversal_EX, ExReversal_IN, InReversal_EX, InReversal_IN;
  logic [31:0] TauExCon_EX, TauExCon_IN, TauInCon_EX, TauInCon_IN;
  logic [31:0] ResetVoltage_EX, ResetVoltage_IN;
  logic [4:0]  Refractory_EX, Refractory_IN;
  logic [63:0] Threshold_EX, Threshold_IN, Threshold;
  logic [63:0] Vmem, gex, gin, ExWeightSum, InWeightSum;
  logic [7:0]  RefVal;
  logic [3:0]  DeltaT;
  logic        SpikeBuffer;
  logic [63:0] VmemOut, gexOut, ginOut;
  logic [7:0]  RefValOut;

  conductance_lif_neuron_unit dut (
    .Clock(Clock), .Reset(Reset), .UpdateEnable(UpdateEnable), .Initialize(Initialize),
    .NeuronType(NeuronType),
    .RestVoltage_EX(RestVoltage_EX), .RestVoltage_IN(RestVoltage_IN),
    .Taumembrane_EX(Taumembrane_EX), .Taumembrane_IN(Taumembrane_IN),
    .ExReversal_EX(ExReversal_EX), .ExReversal_IN(ExReversal_IN),
    .InReversal_EX(InReversal_EX), .InReversal_IN(InReversal_IN),
    .TauExCon_EX(TauExCon_EX), .TauExCon_IN(TauExCon_IN),
    .TauInCon_EX(TauInCon_EX), .TauInCon_IN(TauInCon_IN),
    .ResetVoltage_EX(ResetVoltage_EX), .ResetVoltage_IN(ResetVoltage_IN),
    .Refractory_EX(Refractory_EX), .Refractory_IN(Refractory_IN),
    .Threshold_EX(Threshold_EX), .Threshold_IN(Threshold_IN), .Threshold(Threshold),
    .Vmem(Vmem), .gex(gex), .gin(gin), .RefVal(RefVal), .DeltaT(DeltaT),
    .ExWeightSum(ExWeightSum), .InWeightSum(InWeightSum),
    .SpikeBuffer(SpikeBuffer), .VmemOut(VmemOut), .gexOut(gexOut), .ginOut(ginOut),
    .RefValOut(RefValOut)
  );

  exp_t  exp_q[$];
  string name_q[$];
  exp_t  last_exp;
  logic  chk = 1'b0;
  int    n_tests = 0;
  int    n_fail  = 0;

  function automatic logic [63:0] fx(input int v);
    return 64'(longint'(v) * 64'sd4294967296);
  endfunction

  function automatic exp_t mk(input logic s, input logic [63:0] v, input logic [63:0] ge,
                              input logic [63:0] gi, input logic [7:0] r);
    exp_t e;
    e.spike = s; e.vmem = v; e.gex = ge; e.gin = gi; e.refval = r;
    return e;
  endfunction

  // Present one cycle of stimulus and queue the result expected on the following edge.
  task automatic step(input string nm, input logic rst, input logic init, input logic upd,
                      input logic typ, input logic [63:0] vm, input logic [63:0] ge,
                      input logic [63:0] gi, input logic [63:0] exs, input logic [63:0] ins,
                      input logic [7:0] rv, input exp_t e);
    Reset = rst; Initialize = init; UpdateEnable = upd; NeuronType = typ;
    Vmem = vm; gex = ge; gin = gi; ExWeightSum = exs; InWeightSum = ins; RefVal = rv;
    Threshold = typ ? Threshold_IN : Threshold_EX;
    chk = 1'b1;
    exp_q.push_back(e);
    name_q.push_back(nm);
    last_exp = e;
    @(negedge Clock);
  endtask

  // Monitor: every checked edge pops one expectation and compares all outputs.
  initial begin
    logic  sampled;
    exp_t  e;
    string nm;
    forever begin
      @(posedge Clock);
      sampled = chk;
      #1;
      if (sampled) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL no_expectation: output present but scoreboard empty");
        end else begin
          e  = exp_q.pop_front();
          nm = name_q.pop_front();
          if ({SpikeBuffer, VmemOut, gexOut, ginOut, RefValOut} !== e) begin
            n_fail++;
            $display("FAIL %s: got spk=%0b v=%0d ge=%0d gi=%0d ref=%0d, want spk=%0b v=%0d ge=%0d gi=%0d ref=%0d",
                     nm, SpikeBuffer, $signed(VmemOut), $signed(gexOut), $signed(ginOut), RefValOut,
                     e.spike, $signed(e.vmem), $signed(e.gex), $signed(e.gin), e.refval);
          end
        end
      end
    end
  end

  initial begin
    RestVoltage_EX = -32'sd65; Taumembrane_EX = 32'd100; ExReversal_EX = 32'd0;
    InReversal_EX  = -32'sd80; TauExCon_EX = 32'd1; TauInCon_EX = 32'd4;
    ResetVoltage_EX = -32'sd65; Refractory_EX = 5'd5; Threshold_EX = fx(-52);
    RestVoltage_IN = -32'sd60; Taumembrane_IN = 32'd10; ExReversal_IN = 32'd20;
    InReversal_IN  = -32'sd80; TauExCon_IN = 32'd2; TauInCon_IN = 32'd4;
    ResetVoltage_IN = -32'sd45; Refractory_IN = 5'd2; Threshold_IN = fx(-40);
    DeltaT = 4'd8;

    step("reset", 0, 0, 0, 0, '0, '0, '0, '0, '0, 8'd0, mk(0, '0, '0, '0, 8'd0));
    step("init_ex", 1, 1, 0, 0, '0, '0, '0, '0, '0, 8'd0, mk(0, fx(-65), '0, '0, 8'd0));
    step("leak_rest", 1, 0, 1, 0, fx(-105), '0, '0, '0, '0, 8'd0,
         mk(0, -64'sd450112572621, '0, '0, 8'd0));
    step("gex_decay", 1, 0, 1, 0, fx(-65), ONE, '0, '0, '0, 8'd0,
         mk(0, -64'sd277777009869, HALF, '0, 8'd0));
    step("gex_wsum", 1, 0, 1, 0, fx(-65), ONE, '0, fx(2), '0, 8'd0,
         mk(0, -64'sd277777009869, 64'd10737418240, '0, 8'd0));
    step("gin_inhib", 1, 0, 1, 0, fx(-65), '0, ONE, '0, 64'h4000_0000, 8'd0,
         mk(0, -64'sd279494996787, '0, 64'd4831838208, 8'd0));
    step("spike_ex", 1, 0, 1, 0, fx(-52), ONE, '0, '0, '0, 8'd0,
         mk(1, fx(-65), HALF, '0, 8'd80));
    for (int i = 0; i < 10; i++)
      step($sformatf("refr%0d", i), 1, 0, 1, 0, fx(-65), ONE, '0, '0, '0, 8'(80 - 8 * i),
           mk(0, fx(-65), HALF, '0, 8'(72 - 8 * i)));
    step("post_refr", 1, 0, 1, 0, fx(-65), ONE, '0, '0, '0, 8'd0,
         mk(0, -64'sd277777009869, HALF, '0, 8'd0));
    step("refr_floor", 1, 0, 1, 0, fx(-60), '0, '0, '0, '0, 8'd5, mk(0, fx(-60), '0, '0, 8'd0));
    step("in_nospike", 1, 0, 1, 1, fx(-39), '0, '0, '0, '0, 8'd0,
         mk(0, -64'sd172013440204, '0, '0, 8'd0));
    step("in_spike", 1, 0, 1, 1, fx(-39), ONE, '0, '0, '0, 8'd0,
         mk(1, fx(-45), 64'd3221225472, '0, 8'd32));
    step("saturate", 1, 0, 1, 0, fx(-65), 64'h4000_0000_0000_0000, ~ONE + 64'd1, MAXV, MINV, 8'd0,
         mk(1, fx(-65), MAXV, MINV, 8'd80));
    step("hold_a", 1, 0, 0, 1, fx(-10), ONE, ONE, ONE, ONE, 8'd7, last_exp);
    step("hold_b", 1, 0, 0, 0, fx(3), '0, ONE, fx(5), '0, 8'd0, last_exp);
    TauExCon_EX = 32'd0; Taumembrane_EX = 32'd0;
    step("tau_zero", 1, 0, 1, 0, fx(-65), ONE, '0, '0, '0, 8'd0, mk(0, fx(-65), ONE, '0, 8'd0));
    TauExCon_EX = 32'd1; Taumembrane_EX = 32'd100;
    step("reset_mid", 0, 1, 1, 1, fx(-39), ONE, ONE, ONE, ONE, 8'd0, mk(0, '0, '0, '0, 8'd0));
    step("hold_zero", 1, 0, 0, 0, fx(-39), ONE, ONE, ONE, ONE, 8'd9, last_exp);
    step("init_prio", 1, 1, 1, 1, fx(-39), ONE, ONE, ONE, ONE, 8'd16, mk(0, fx(-45), '0, '0, 8'd0));
    chk = 1'b0;
    UpdateEnable = 1'b0; Initialize = 1'b0;

    for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(negedge Clock);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
